mem_port_arbiter: RTL and testbench

//  Shares the single read/write port (port 0) of the on-chip SRAM macro wrapper between NUM_REQ requesters.

---
 rtl/mem_port_arbiter.sv | 119 +++++++++++
 tb/tb_mem_port_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the SRAM read/write port between NUM_REQ requesters.
// Registers one command per cycle onto the active-low macro port and tags read returns.
module mem_port_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int WORD_SIZE = 32,
  parameter int NUM_WORDS = 1024,
  localparam int AW  = $clog2(NUM_WORDS),
  localparam int WMW = WORD_SIZE / 8,
  localparam int IDW = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         IN_stall,
  input  logic [NUM_REQ-1:0]           IN_valid,
  input  logic [NUM_REQ-1:0]           IN_we,
  input  logic [NUM_REQ*AW-1:0]        IN_addr,
  input  logic [NUM_REQ*WORD_SIZE-1:0] IN_data,
  input  logic [NUM_REQ*WMW-1:0]       IN_wm,
  output logic [NUM_REQ-1:0]           OUT_ready,
  output logic [NUM_REQ-1:0]           OUT_rvalid,
  output logic [WORD_SIZE-1:0]         OUT_rdata,
  output logic                         OUT_mem_nce,
  output logic                         OUT_mem_nwe,
  output logic [AW-1:0]                OUT_mem_addr,
  output logic [WORD_SIZE-1:0]         OUT_mem_data,
  output logic [WMW-1:0]               OUT_mem_wm,
  input  logic [WORD_SIZE-1:0]         IN_mem_data
);

  localparam logic [IDW:0] NREQ_W = (IDW+1)'(NUM_REQ);

  logic [AW-1:0]        addr_arr [NUM_REQ];
  logic [WORD_SIZE-1:0] data_arr [NUM_REQ];
  logic [WMW-1:0]       wm_arr   [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi] = IN_addr[gi*AW +: AW];
      assign data_arr[gi] = IN_data[gi*WORD_SIZE +: WORD_SIZE];
      assign wm_arr[gi]   = IN_wm[gi*WMW +: WMW];
    end
  endgenerate

  logic [IDW-1:0] ptr_reg;
  logic [IDW-1:0] ptr_next;
  logic [IDW-1:0] gnt_id;
  logic           accept;
  logic           accept_we;
  logic [IDW:0]   cand_sum;

  // Search ptr, ptr+1, ... wrapping; the first valid requester wins.
  always_comb begin
    OUT_ready = '0;
    gnt_id    = '0;
    accept    = 1'b0;
    cand_sum  = '0;
    if (!IN_stall && !rst) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand_sum = {1'b0, ptr_reg} + (IDW+1)'(k);
        if (cand_sum >= NREQ_W) cand_sum = cand_sum - NREQ_W;
        if (!accept && IN_valid[cand_sum[IDW-1:0]]) begin
          accept    = 1'b1;
          gnt_id    = cand_sum[IDW-1:0];
          OUT_ready[cand_sum[IDW-1:0]] = 1'b1;
        end
      end
    end
  end

  assign accept_we = IN_we[gnt_id];
  assign ptr_next  = (gnt_id == IDW'(NUM_REQ-1)) ? '0 : gnt_id + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg      <= '0;
      OUT_mem_nce  <= 1'b1;
      OUT_mem_nwe  <= 1'b1;
      OUT_mem_addr <= '0;
      OUT_mem_data <= '0;
      OUT_mem_wm   <= '0;
    end else if (accept) begin
      ptr_reg      <= ptr_next;
      OUT_mem_nce  <= 1'b0;
      OUT_mem_nwe  <= ~accept_we;
      OUT_mem_addr <= addr_arr[gnt_id];
      OUT_mem_data <= data_arr[gnt_id];
      OUT_mem_wm   <= wm_arr[gnt_id];
    end else begin
      OUT_mem_nce  <= 1'b1;
      OUT_mem_nwe  <= 1'b1;
    end
  end

  // Three stages match the command register plus the macro's two internal edges.
  logic [2:0]     pipe_valid_reg;
  logic [IDW-1:0] pipe_id_reg [3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_valid_reg <= '0;
      for (int s = 0; s < 3; s++) pipe_id_reg[s] <= '0;
    end else begin
      pipe_valid_reg <= {pipe_valid_reg[1:0], accept & ~accept_we};
      pipe_id_reg[0] <= gnt_id;
      pipe_id_reg[1] <= pipe_id_reg[0];
      pipe_id_reg[2] <= pipe_id_reg[1];
    end
  end

  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_rvalid
      assign OUT_rvalid[gi] = pipe_valid_reg[2] && (pipe_id_reg[2] == IDW'(gi));
    end
  endgenerate

  assign OUT_rdata = IN_mem_data;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural SRAM model
// (inputs registered, access on the following edge, no reset inside the macro).
module tb_mem_port_arbiter;

  localparam int AW = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [1:0]  valid, we;
  logic [19:0] addr;
  logic [63:0] wdata;
  logic [7:0]  wm;
  logic [1:0]  ready, rvalid;
  logic [31:0] rdata;
  logic        mem_nce, mem_nwe;
  logic [9:0]  mem_addr;
  logic [31:0] mem_data, mem_rdata;
  logic [3:0]  mem_wm;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.NUM_REQ(2), .WORD_SIZE(32), .NUM_WORDS(1024)) dut (
    .clk(clk), .rst(rst), .IN_stall(stall), .IN_valid(valid), .IN_we(we),
    .IN_addr(addr), .IN_data(wdata), .IN_wm(wm), .OUT_ready(ready),
    .OUT_rvalid(rvalid), .OUT_rdata(rdata), .OUT_mem_nce(mem_nce),
    .OUT_mem_nwe(mem_nwe), .OUT_mem_addr(mem_addr), .OUT_mem_data(mem_data),
    .OUT_mem_wm(mem_wm), .IN_mem_data(mem_rdata)
  );

  logic [31:0] sram [1024];
  logic        s_nce = 1'b1, s_nwe = 1'b1;
  logic [9:0]  s_addr = '0;
  logic [31:0] s_data = '0;
  logic [3:0]  s_wm = '0;

  always @(posedge clk) begin
    if (!s_nce) begin
      if (!s_nwe) begin
        for (int b = 0; b < 4; b++)
          if (s_wm[b]) sram[s_addr][b*8 +: 8] <= s_data[b*8 +: 8];
      end else begin
        mem_rdata <= sram[s_addr];
      end
    end
    s_nce  <= mem_nce;
    s_nwe  <= mem_nwe;
    s_addr <= mem_addr;
    s_data <= mem_data;
    s_wm   <= mem_wm;
  end

  typedef struct {
    logic [1:0]  valid, we;
    logic [9:0]  a0, a1;
    logic [31:0] d0, d1;
    logic [3:0]  m0, m1;
    logic        stall;
    logic [1:0]  exp_ready, exp_rvalid;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [24];

  function automatic vec_t mk(logic [1:0] v, logic [1:0] w, logic [9:0] a0, logic [9:0] a1,
                              logic [31:0] d0, logic [31:0] d1, logic [3:0] m0, logic [3:0] m1,
                              logic st, logic [1:0] er, logic [1:0] erv, logic [31:0] erd);
    vec_t r;
    r.valid = v; r.we = w; r.a0 = a0; r.a1 = a1; r.d0 = d0; r.d1 = d1;
    r.m0 = m0; r.m1 = m1; r.stall = st; r.exp_ready = er; r.exp_rvalid = erv; r.exp_rdata = erd;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    valid = v.valid; we = v.we; addr = {v.a1, v.a0};
    wdata = {v.d1, v.d0}; wm = {v.m1, v.m0}; stall = v.stall;
  endtask

  vec_t idle_v;
  logic        prev_acc, prev_we;
  logic [9:0]  prev_addr;
  logic [31:0] prev_data;
  logic [3:0]  prev_wm;

  initial begin
    sram[3] = 32'h33333333; sram[5] = 32'hDEADBEEF; sram[7] = 32'h07070707;
    sram[8] = 32'h08080808; sram[9] = 32'hAAAAAAAA;
    mem_rdata = '0;
    idle_v = mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);

    //             valid  we     a0  a1  d0            d1            m0 m1 st ready  rvalid rdata
    vecs[0]  = mk(2'b00, 2'b00, 0,  0,  0,            0,            0, 0, 0, 2'b00, 2'b00, 0);
    vecs[1]  = mk(2'b01, 2'b00, 5,  0,  0,            0,            0, 0, 0, 2'b01, 2'b00, 0);
    vecs[2]  = idle_v;
    vecs[3]  = idle_v;
    vecs[4]  = mk(2'b00, 2'b00, 0,  0,  0,            0,            0, 0, 0, 2'b00, 2'b01, 32'hDEADBEEF);
    vecs[5]  = mk(2'b10, 2'b00, 0,  3,  0,            0,            0, 0, 0, 2'b10, 2'b00, 0);
    vecs[6]  = mk(2'b11, 2'b00, 7,  8,  0,            0,            0, 0, 0, 2'b01, 2'b00, 0);
    vecs[7]  = mk(2'b11, 2'b00, 7,  8,  0,            0,            0, 0, 0, 2'b10, 2'b00, 0);
    vecs[8]  = mk(2'b11, 2'b00, 7,  8,  0,            0,            0, 0, 0, 2'b01, 2'b10, 32'h33333333);
    vecs[9]  = mk(2'b11, 2'b00, 7,  8,  0,            0,            0, 0, 0, 2'b10, 2'b01, 32'h07070707);
    vecs[10] = mk(2'b01, 2'b01, 9,  0,  32'h11223344, 0,            5, 0, 0, 2'b01, 2'b10, 32'h08080808);
    vecs[11] = mk(2'b01, 2'b00, 9,  0,  0,            0,            0, 0, 0, 2'b01, 2'b01, 32'h07070707);
    vecs[12] = mk(2'b10, 2'b10, 0,  9,  0,            32'hFFFFFFFF, 0, 0, 0, 2'b10, 2'b10, 32'h08080808);
    vecs[13] = mk(2'b10, 2'b00, 0,  9,  0,            0,            0, 0, 0, 2'b10, 2'b00, 0);
    vecs[14] = mk(2'b00, 2'b00, 0,  0,  0,            0,            0, 0, 0, 2'b00, 2'b01, 32'hAA22AA44);
    vecs[15] = idle_v;
    vecs[16] = mk(2'b11, 2'b00, 5,  3,  0,            0,            0, 0, 0, 2'b01, 2'b10, 32'hAA22AA44);
    vecs[17] = mk(2'b11, 2'b00, 5,  3,  0,            0,            0, 0, 1, 2'b00, 2'b00, 0);
    vecs[18] = mk(2'b11, 2'b00, 5,  3,  0,            0,            0, 0, 1, 2'b00, 2'b00, 0);
    vecs[19] = mk(2'b11, 2'b00, 5,  3,  0,            0,            0, 0, 1, 2'b00, 2'b01, 32'hDEADBEEF);
    vecs[20] = mk(2'b11, 2'b00, 5,  3,  0,            0,            0, 0, 0, 2'b10, 2'b00, 0);
    vecs[21] = idle_v;
    vecs[22] = idle_v;
    vecs[23] = mk(2'b00, 2'b00, 0,  0,  0,            0,            0, 0, 0, 2'b00, 2'b10, 32'h33333333);

    // Reset state, with requests pending to show grants are masked by reset.
    rst = 1'b1;
    drive(idle_v);
    valid = 2'b11;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", {30'd0, ready}, 32'd0);
    chk("reset_rvalid", {30'd0, rvalid}, 32'd0);
    chk("reset_nce", {31'd0, mem_nce}, 32'd1);
    chk("reset_nwe", {31'd0, mem_nwe}, 32'd1);
    chk("reset_addr", {22'd0, mem_addr}, 32'd0);
    chk("reset_wm", {28'd0, mem_wm}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(idle_v);

    prev_acc = 1'b0; prev_we = 1'b0; prev_addr = '0; prev_data = '0; prev_wm = '0;
    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1;
      drive(vecs[i]);
      @(negedge clk);
      $display("row %0d valid=%b stall=%b ready=%b rvalid=%b rdata=%h nce=%b",
               i, valid, stall, ready, rvalid, rdata, mem_nce);
      chk($sformatf("row%0d_ready", i), {30'd0, ready}, {30'd0, vecs[i].exp_ready});
      chk($sformatf("row%0d_rvalid", i), {30'd0, rvalid}, {30'd0, vecs[i].exp_rvalid});
      if (vecs[i].exp_rvalid != 2'b00)
        chk($sformatf("row%0d_rdata", i), rdata, vecs[i].exp_rdata);
      chk($sformatf("row%0d_nce", i), {31'd0, mem_nce}, {31'd0, ~prev_acc});
      if (prev_acc) begin
        chk($sformatf("row%0d_nwe", i), {31'd0, mem_nwe}, {31'd0, ~prev_we});
        chk($sformatf("row%0d_addr", i), {22'd0, mem_addr}, {22'd0, prev_addr});
        if (prev_we) begin
          chk($sformatf("row%0d_wdata", i), mem_data, prev_data);
          chk($sformatf("row%0d_wm", i), {28'd0, mem_wm}, {28'd0, prev_wm});
        end
      end
      prev_acc = (vecs[i].exp_ready != 2'b00);
      if (vecs[i].exp_ready[1]) begin
        prev_we = vecs[i].we[1]; prev_addr = vecs[i].a1; prev_data = vecs[i].d1; prev_wm = vecs[i].m1;
      end else begin
        prev_we = vecs[i].we[0]; prev_addr = vecs[i].a0; prev_data = vecs[i].d0; prev_wm = vecs[i].m0;
      end
    end

    // Reset mid-flight: read accepted by req0 (pointer moves to 1), reset the next cycle.
    @(posedge clk); #1;
    drive(mk(2'b01, 2'b00, 5, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
    @(negedge clk);
    $display("rst_seq accept ready=%b", ready);
    chk("rst_seq_accept", {30'd0, ready}, 32'd1);
    @(posedge clk); #1;
    valid = 2'b11; addr = {10'd3, 10'd5}; we = 2'b00;
    chk("rst_seq_nce_before", {31'd0, mem_nce}, 32'd0);
    rst = 1'b1;
    #1;
    $display("rst_seq asserted ready=%b nce=%b rvalid=%b", ready, mem_nce, rvalid);
    chk("rst_seq_nce_async", {31'd0, mem_nce}, 32'd1);
    chk("rst_seq_ready", {30'd0, ready}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    valid = 2'b00;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      $display("rst_seq drain %0d rvalid=%b", c, rvalid);
      chk($sformatf("rst_seq_drain%0d", c), {30'd0, rvalid}, 32'd0);
      @(posedge clk); #1;
    end
    valid = 2'b11;
    @(negedge clk);
    $display("rst_seq post_reset ready=%b", ready);
    chk("rst_seq_ptr_zero", {30'd0, ready}, 32'd1);
    @(posedge clk); #1;
    valid = 2'b00;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      $display("rst_seq return +%0d rvalid=%b rdata=%h", c, rvalid, rdata);
      chk($sformatf("rst_seq_rvalid_p%0d", c), {30'd0, rvalid}, (c == 3) ? 32'd1 : 32'd0);
      if (c == 3) chk("rst_seq_rdata", rdata, 32'hDEADBEEF);
      @(posedge clk); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
